// File: rtl/if_pc_gen_pkg.sv
// Shared defaults and FSM encodings for the instruction-fetch PC generator.
package if_pc_gen_pkg;

    localparam int                           INST_ADDR_BUS_W  = 32;
    localparam logic [INST_ADDR_BUS_W-1:0]   RESET_PC_DEFAULT = '0;
    localparam int                           EPOCH_W_DEFAULT  = 2;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } pc_state_e;

endpackage

// File: rtl/if_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous update.
// Writes land at the clock edge, so a same-cycle lookup sees the old entry.
module if_btb
    import if_pc_gen_pkg::*;
#(
    parameter int ADDR_W     = INST_ADDR_BUS_W,
    parameter int INST_BYTES = 4,
    parameter int DEPTH      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              lookup_hit,
    output logic [ADDR_W-1:0] lookup_target,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken
);

    localparam int OFF_W = $clog2(INST_BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    logic [DEPTH-1:0]  valid;
    logic [TAG_W-1:0]  tags    [DEPTH];
    logic [ADDR_W-1:0] targets [DEPTH];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] up_tag;
    logic             unused_off;

    assign lk_idx = lookup_pc[OFF_W +: IDX_W];
    assign lk_tag = lookup_pc[ADDR_W-1 -: TAG_W];
    assign up_idx = upd_pc[OFF_W +: IDX_W];
    assign up_tag = upd_pc[ADDR_W-1 -: TAG_W];

    // Byte-offset bits never participate in index or tag.
    assign unused_off = ^{lookup_pc[OFF_W-1:0], upd_pc[OFF_W-1:0]};

    assign lookup_hit    = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    assign lookup_target = targets[lk_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (upd_en) begin
            if (upd_taken) begin
                valid[up_idx] <= 1'b1;
            end else if (tags[up_idx] == up_tag) begin
                valid[up_idx] <= 1'b0;
            end
        end
    end

    // Tag/target storage needs no reset: valid bits gate every hit.
    always_ff @(posedge clk) begin
        if (upd_en && upd_taken) begin
            tags[up_idx]    <= up_tag;
            targets[up_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/if_pc_gen.sv
// Fetch-stage PC generator with valid/ready handshake, redirect epochs and
// optional BTB prediction (enabled by defining IF_PC_GEN_BTB_EN).
module if_pc_gen
    import if_pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = INST_ADDR_BUS_W,
    parameter int                INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                EPOCH_W    = EPOCH_W_DEFAULT,
    parameter int                BTB_DEPTH  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [ADDR_W-1:0]  fetch_pc,
    output logic [EPOCH_W-1:0] fetch_epoch,
    output logic               fetch_pred_taken,
    input  logic               btb_upd_valid,
    input  logic [ADDR_W-1:0]  btb_upd_pc,
    input  logic [ADDR_W-1:0]  btb_upd_target,
    input  logic               btb_upd_taken
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);

    pc_state_e          state, state_nxt;
    logic [ADDR_W-1:0]  pc_nxt;
    logic [EPOCH_W-1:0] epoch_nxt;
    logic [ADDR_W-1:0]  next_seq;
    logic [ADDR_W-1:0]  next_pc;
    logic               fire;

    assign fetch_valid = (state == S_RUN);
    assign next_seq    = fetch_pc + ADDR_W'(INST_BYTES);
    assign fire        = fetch_valid & fetch_ready & ~stall & rdy & ~redirect;

`ifdef IF_PC_GEN_BTB_EN
    logic              btb_hit;
    logic [ADDR_W-1:0] btb_target;

    // Training freezes with the rest of the block while rdy is low.
    if_btb #(
        .ADDR_W     (ADDR_W),
        .INST_BYTES (INST_BYTES),
        .DEPTH      (BTB_DEPTH)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .lookup_pc     (fetch_pc),
        .lookup_hit    (btb_hit),
        .lookup_target (btb_target),
        .upd_en        (btb_upd_valid & rdy),
        .upd_pc        (btb_upd_pc),
        .upd_target    (btb_upd_target),
        .upd_taken     (btb_upd_taken)
    );

    assign fetch_pred_taken = fetch_valid & btb_hit;
    assign next_pc          = fetch_pred_taken ? btb_target : next_seq;
`else
    logic unused_btb;

    assign unused_btb       = ^{btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken};
    assign fetch_pred_taken = 1'b0;
    assign next_pc          = next_seq;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = fetch_pc;
        epoch_nxt = fetch_epoch;
        unique case (state)
            S_BOOT: begin
                if (rdy) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Redirect wins over the handshake, even when stalled.
                if (rdy && redirect) begin
                    pc_nxt    = redirect_pc & ALIGN_MASK;
                    epoch_nxt = fetch_epoch + EPOCH_W'(1);
                end else if (fire) begin
                    pc_nxt = next_pc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_BOOT;
            fetch_pc    <= RESET_PC;
            fetch_epoch <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= pc_nxt;
            fetch_epoch <= epoch_nxt;
        end
    end

endmodule

// File: tb/tb_if_pc_gen.sv
// Scoreboard bench for if_pc_gen: a reference model predicts the post-edge
// outputs for every driven cycle, which are popped and compared after the edge.
module tb_if_pc_gen;

`ifdef IF_PC_GEN_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rdy, stall, redirect, fetch_ready;
    logic [31:0] redirect_pc;
    logic        btb_upd_valid, btb_upd_taken;
    logic [31:0] btb_upd_pc, btb_upd_target;
    logic        fetch_valid, fetch_pred_taken;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_epoch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_pc_gen dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_pc         (fetch_pc),
        .fetch_epoch      (fetch_epoch),
        .fetch_pred_taken (fetch_pred_taken),
        .btb_upd_valid    (btb_upd_valid),
        .btb_upd_pc       (btb_upd_pc),
        .btb_upd_target   (btb_upd_target),
        .btb_upd_taken    (btb_upd_taken)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [1:0]  ep;
        logic        pt;
    } exp_t;

    exp_t sb[$];

    logic        m_run;
    logic [31:0] m_pc;
    logic [1:0]  m_ep;
    logic [7:0]  m_bv;
    logic [26:0] m_btag [8];
    logic [31:0] m_btgt [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_hit(input logic [31:0] pc);
        return BTB_ON && m_bv[pc[4:2]] && (m_btag[pc[4:2]] == pc[31:5]);
    endfunction

    // Advance the model by one clock with the currently driven inputs, then
    // clock the DUT and compare against what the model predicted.
    task automatic step();
        exp_t        e;
        logic        pt;
        logic [2:0]  idx;
        pt = m_run && m_hit(m_pc);
        if (rst) begin
            m_run = 1'b0;
            m_pc  = 32'h0;
            m_ep  = 2'd0;
            m_bv  = '0;
        end else if (rdy) begin
            if (!m_run) begin
                m_run = 1'b1;
            end else if (redirect) begin
                m_pc = redirect_pc & ~32'h3;
                m_ep = m_ep + 2'd1;
            end else if (fetch_ready && !stall) begin
                m_pc = pt ? m_btgt[m_pc[4:2]] : m_pc + 32'd4;
            end
            if (BTB_ON && btb_upd_valid) begin
                idx = btb_upd_pc[4:2];
                if (btb_upd_taken) begin
                    m_bv[idx]   = 1'b1;
                    m_btag[idx] = btb_upd_pc[31:5];
                    m_btgt[idx] = btb_upd_target;
                end else if (m_btag[idx] == btb_upd_pc[31:5]) begin
                    m_bv[idx] = 1'b0;
                end
            end
        end
        e = '{v: m_run, pc: m_pc, ep: m_ep, pt: m_run && m_hit(m_pc)};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("sb_valid", fetch_valid, e.v);
            chk("sb_pc", fetch_pc, e.pc);
            chk("sb_epoch", fetch_epoch, e.ep);
            chk("sb_pred", fetch_pred_taken, e.pt);
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        fetch_ready = 1'b0; btb_upd_valid = 1'b0; btb_upd_taken = 1'b0;
        btb_upd_pc = '0; btb_upd_target = '0;
        m_run = 1'b0; m_pc = '0; m_ep = '0; m_bv = '0;
        for (int i = 0; i < 8; i++) begin
            m_btag[i] = '0;
            m_btgt[i] = '0;
        end

        step(); step();
        chk("rst_valid", fetch_valid, 32'd0);
        chk("rst_pc", fetch_pc, 32'h0);
        chk("rst_epoch", fetch_epoch, 32'd0);
        chk("rst_pred", fetch_pred_taken, 32'd0);

        rst = 1'b0; rdy = 1'b0; step();
        chk("boot_wait_rdy", fetch_valid, 32'd0);

        rdy = 1'b1; fetch_ready = 1'b1;
        step(); chk("first_req_valid", fetch_valid, 32'd1); chk("seq0", fetch_pc, 32'h0);
        step(); chk("seq1", fetch_pc, 32'h4);
        step(); chk("seq2", fetch_pc, 32'h8);
        fetch_ready = 1'b0;
        repeat (3) step();
        chk("hold_ready_pc", fetch_pc, 32'h8);
        chk("hold_ready_valid", fetch_valid, 32'd1);
        fetch_ready = 1'b1; stall = 1'b1;
        repeat (2) step();
        chk("hold_stall_pc", fetch_pc, 32'h8);
        stall = 1'b0; step();
        chk("seq3", fetch_pc, 32'hC);
        chk("seq_epoch", fetch_epoch, 32'd0);

        redirect = 1'b1; redirect_pc = 32'h103; step();
        chk("redir_pc", fetch_pc, 32'h100);
        chk("redir_epoch", fetch_epoch, 32'd1);
        stall = 1'b1; redirect_pc = 32'h200; step();
        chk("redir_stall_pc", fetch_pc, 32'h200);
        stall = 1'b0; rdy = 1'b0; redirect_pc = 32'h300; step();
        chk("rdy0_pc", fetch_pc, 32'h200);
        chk("rdy0_epoch", fetch_epoch, 32'd2);
        rdy = 1'b1; step();
        redirect_pc = 32'h400; step();
        chk("epoch_wrap", fetch_epoch, 32'd0);
        chk("epoch_wrap_pc", fetch_pc, 32'h400);

        redirect_pc = 32'hFFFF_FFFC; step();
        redirect = 1'b0; step();
        chk("pc_wrap", fetch_pc, 32'h0);

        // Train 0x10 -> 0x40 while redirecting there: visible on the next cycle.
        fetch_ready = 1'b0;
        btb_upd_valid = 1'b1; btb_upd_taken = 1'b1;
        btb_upd_pc = 32'h10; btb_upd_target = 32'h40;
        redirect = 1'b1; redirect_pc = 32'h10; step();
        redirect = 1'b0; btb_upd_valid = 1'b0;
        chk("btb_pred", fetch_pred_taken, 32'(BTB_ON));
        // Untrain in the same cycle the prediction is consumed: old entry wins.
        fetch_ready = 1'b1; btb_upd_valid = 1'b1; btb_upd_taken = 1'b0; step();
        btb_upd_valid = 1'b0;
        chk("btb_target", fetch_pc, BTB_ON ? 32'h40 : 32'h14);
        redirect = 1'b1; fetch_ready = 1'b0; step();
        redirect = 1'b0;
        chk("btb_untrained", fetch_pred_taken, 32'd0);
        fetch_ready = 1'b1; step();
        chk("btb_seq", fetch_pc, 32'h14);

        btb_upd_valid = 1'b1; btb_upd_taken = 1'b1;
        redirect = 1'b1; fetch_ready = 1'b0; step();
        btb_upd_valid = 1'b0;
        rst = 1'b1; rdy = 1'b0; stall = 1'b1; redirect_pc = 32'h80; step();
        chk("mid_rst_valid", fetch_valid, 32'd0);
        chk("mid_rst_pc", fetch_pc, 32'h0);
        chk("mid_rst_epoch", fetch_epoch, 32'd0);
        rst = 1'b0; rdy = 1'b1; stall = 1'b0; redirect = 1'b0; step();
        redirect = 1'b1; redirect_pc = 32'h10; step();
        redirect = 1'b0;
        chk("btb_cleared", fetch_pred_taken, 32'd0);

        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(0, 63) == 0);
            rdy            = ($urandom_range(0, 7) != 0);
            stall          = ($urandom_range(0, 5) == 0);
            redirect       = ($urandom_range(0, 7) == 0);
            redirect_pc    = 32'($urandom_range(0, 255));
            fetch_ready    = ($urandom_range(0, 3) != 0);
            btb_upd_valid  = ($urandom_range(0, 3) == 0);
            btb_upd_taken  = ($urandom_range(0, 2) != 0);
            btb_upd_pc     = 32'($urandom_range(0, 63)) << 2;
            btb_upd_target = 32'($urandom_range(0, 63)) << 2;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_pc_gen.md
# if_pc_gen

Parametrised program-counter generator for the instruction-fetch stage, successor to the single-issue PC register. It produces a stream of fetch addresses over a valid/ready handshake, accepts redirects from the execute stage, tags every fetch with a redirect epoch so downstream can drop stale instructions, and optionally predicts taken branches with a small direct-mapped BTB. It sits between the pipeline control unit and the instruction cache/memory controller.

## Interface
- ADDR_W, 32, PC width in bits
- INST_BYTES, 4, instruction size in bytes (power of two, ≥2); sequential increment
- RESET_PC, 0, first fetch address after reset
- EPOCH_W, 2, epoch tag width
- BTB_DEPTH, 8, BTB entries (power of two, ≥2); used only with BTB_EN
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- stall  in  1  pipeline stall; blocks PC advance
- redirect  in  1  branch/jump resolved as mispredicted
- redirect_pc  in  ADDR_W  corrected target
- fetch_valid  out  1  fetch_pc is a live request
- fetch_ready  in  1  consumer accepts the current request
- fetch_pc  out  ADDR_W  fetch address
- fetch_epoch  out  EPOCH_W  epoch of the current request
- fetch_pred_taken  out  1  BTB hit; next PC is the predicted target
- btb_upd_valid  in  1  BTB training strobe
- btb_upd_pc  in  ADDR_W  branch PC being trained
- btb_upd_target  in  ADDR_W  resolved target
- btb_upd_taken  in  1  resolved direction

## Operation
- FSM: S_BOOT → S_RUN. In S_BOOT fetch_valid=0; redirect ignored; on rdy=1 go to S_RUN with fetch_valid←1, fetch_pc=RESET_PC.
- fire = fetch_valid & fetch_ready & !stall & rdy & !redirect.
- next_seq = fetch_pc + INST_BYTES, modulo 2^ADDR_W (wraps silently).
- next_pc = fetch_pred_taken ? BTB target : next_seq.
- Priority, S_RUN, rdy=1: redirect > fire > hold.
  - redirect: fetch_pc ← redirect_pc with low log2(INST_BYTES) bits cleared; fetch_epoch ← fetch_epoch+1 (mod 2^EPOCH_W); any same-cycle handshake is void. Applies even under stall.
  - fire: fetch_pc ← next_pc.
  - otherwise fetch_pc, fetch_epoch held stable (fetch_valid stays 1).
- rdy=0: no state change at all (unlike reset).
- fetch_pred_taken combinational from the BTB lookup of the current fetch_pc; 0 when fetch_valid=0.
- BTB (BTB_EN): index = pc[log2(INST_BYTES) +: log2(BTB_DEPTH)], tag = bits above index, entry = {valid, tag, target}. Hit = valid & tag match.
  - Update with taken=1: write entry {1, tag, target}.
  - Update with taken=0: clear valid only if the entry's tag matches.
  - Writes land at the clock edge; same-cycle lookup at the same index sees old contents.

## Timing
- Reset values: fetch_valid=0, fetch_pc=RESET_PC, fetch_epoch=0, fetch_pred_taken=0, state=S_BOOT, all BTB valid bits 0.
- First request: one cycle after the first clk edge with rst=0 and rdy=1.
- Redirect-to-request latency: 1 cycle; the new fetch_pc is valid on the following cycle.
- Back-to-back: one request per cycle while fetch_ready=1 and stall=0.
- BTB training is visible to lookups one cycle after btb_upd_valid.
- rst mid-operation: returns to reset values on that edge regardless of rdy, stall, or redirect.

## Configuration
- IF_PC_GEN_BTB_EN defined: BTB instantiated; prediction and training are active.
- Undefined: no BTB storage; fetch_pred_taken tied 0; next_pc = next_seq; btb_upd_* ports remain present but are ignored.

## Structure
- Shared defines package: InstAddrBus width default, RESET_PC default, EPOCH_W default, and the FSM state encodings S_BOOT and S_RUN.
- One sub-module, if_btb: direct-mapped storage with a combinational lookup port and a synchronous update port, cleared by rst.

## Test plan
- Reset, then rdy=1, fetch_ready=1, 4 cycles → fetch_pc 0x0, 0x4, 0x8, 0xC; epoch 0.
- fetch_ready=0 for 3 cycles at pc 0x8 → fetch_pc holds 0x8 with fetch_valid=1; stall=1 gives the same hold.
- Redirect to 0x103 with fetch_ready=1 → next cycle fetch_pc=0x100, epoch=1; 4 redirects → epoch wraps to 0.
- fetch_pc=0xFFFFFFFC, fire → fetch_pc=0x0.
- BTB_EN: train pc 0x10 → 0x40 taken; fetch reaches 0x10 → pred_taken=1, next fetch_pc 0x40; train 0x10 not-taken → sequential 0x14 on the next pass.
- rst asserted mid-stream with redirect=1 → reset values on the next cycle; BTB is empty (pc 0x10 no longer predicted).
